// File: rtl/pulse_analyzer_pkg.sv
// pulse_analyzer_pkg: default widths and FSM state type for the pulse analyzer.
package pulse_analyzer_pkg;
  localparam int DEF_PERIOD_WIDTH = 16;
  localparam int DEF_PERCENT_WIDTH = 8;
  // One clock per generation tick in simulation; synthesis builds pass SYSTEM_CLOCK / AUDIO_GENERATION_FREQUENCY.
  localparam int DEF_GENERATION_TICKS = 1;
  typedef logic [DEF_PERCENT_WIDTH-1:0] percent_t;
  typedef enum logic {IDLE, MEASURE} analyzer_state_t;
endpackage

// File: rtl/pulse_analyzer_serial_divide.sv
// pulse_analyzer_serial_divide: restoring divider, one quotient bit per cycle, QW cycles per result.
module pulse_analyzer_serial_divide #(
  parameter int DW = 16,
  parameter int QW = 8
)(
  input  logic          clock_50_000_000,
  input  logic          reset_l,
  input  logic          abort,
  input  logic          start,
  input  logic [DW+QW-1:0] dividend,
  input  logic [DW-1:0] divisor,
  output logic          busy,
  output logic          done,
  output logic [QW-1:0] quotient
);
  localparam int SW = $clog2(QW);
  logic [DW-1:0] rem, dsr, diff;
  logic [QW-1:0] low;
  logic [SW-1:0] step;
  logic [DW:0] trial;
  logic sat, fits;
  // low shifts dividend bits out of the top while quotient bits enter at the bottom
  always_comb begin
    trial = {rem, low[QW-1]};
    fits = trial >= {1'b0, dsr};
    diff = trial[DW-1:0] - dsr;
    done = busy && step == SW'(QW - 1);
    quotient = sat ? '1 : {low[QW-2:0], fits};
  end
  always_ff @(posedge clock_50_000_000 or negedge reset_l)
    if (!reset_l) {busy, sat, step, rem, dsr, low} <= '0;
    else if (abort) busy <= 1'b0;
    else if (start) begin
      busy <= 1'b1;
      step <= '0;
      sat <= dividend[DW+QW-1:QW] >= divisor;
      rem <= dividend[DW+QW-1:QW];
      low <= dividend[QW-1:0];
      dsr <= divisor;
    end else if (busy) begin
      busy <= !done;
      step <= step + 1'b1;
      rem <= fits ? diff : trial[DW-1:0];
      low <= {low[QW-2:0], fits};
    end
endmodule

// File: rtl/pulse_analyzer.sv
// pulse_analyzer: measures a 1-bit waveform's period (generation ticks) and duty (percent_t).
module pulse_analyzer
  import pulse_analyzer_pkg::*;
#(
  parameter int PERIOD_WIDTH = DEF_PERIOD_WIDTH,
  parameter int PERCENT_WIDTH = DEF_PERCENT_WIDTH,
  parameter int GENERATION_TICKS = DEF_GENERATION_TICKS,
  parameter int SYNC_STAGES = 2
)(
  input  logic                     clock_50_000_000,
  input  logic                     reset_l,
  input  logic                     clear,
  input  logic                     signal_in,
  output logic [PERIOD_WIDTH-1:0]  period,
  output logic [PERCENT_WIDTH-1:0] duty_cycle,
  output logic                     valid,
  output logic                     locked,
  output logic                     no_signal,
  output logic                     overrun
);
  localparam int PRE_W = GENERATION_TICKS > 1 ? $clog2(GENERATION_TICKS) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(GENERATION_TICKS - 1);
  analyzer_state_t state, state_n;
  logic [SYNC_STAGES-1:0] sync;
  logic level, rise, tick, run, timeout, accept, drop, busy, done;
  logic [PRE_W-1:0] pre, pre_eff, pre_n;
  logic [PERIOD_WIDTH-1:0] period_cnt, high_cnt, period_base, high_base, period_n, high_n, div_period;
  logic [PERCENT_WIDTH-1:0] quotient;
  // level is delayed to line up with rise, so the edge cycle itself counts as high
  always_ff @(posedge clock_50_000_000 or negedge reset_l)
    if (!reset_l) {sync, level, rise} <= '0;
    else begin
      sync <= {sync[SYNC_STAGES-2:0], signal_in};
      level <= sync[SYNC_STAGES-1];
      rise <= sync[SYNC_STAGES-1] & ~level;
    end
  always_comb begin
    pre_eff = rise ? '0 : pre;
    tick = pre_eff == PRE_LAST;
    pre_n = tick ? '0 : pre_eff + 1'b1;
    run = state == MEASURE || rise;
    period_base = rise ? '0 : period_cnt;
    high_base = rise ? '0 : high_cnt;
    period_n = !run ? '0 : tick && period_base != '1 ? period_base + 1'b1 : period_base;
    high_n = !run ? '0 : tick && level && high_base != '1 ? high_base + 1'b1 : high_base;
  end
  always_ff @(posedge clock_50_000_000 or negedge reset_l)
    if (!reset_l) state <= IDLE;
    else state <= clear ? IDLE : state_n;
  always_comb state_n = state == IDLE ? (rise ? MEASURE : IDLE) : (timeout ? IDLE : MEASURE);
  always_comb begin
    timeout = state == MEASURE && !rise && period_cnt == '1;
    accept = state == MEASURE && rise && period_cnt != '0 && (!busy || done);
    drop = state == MEASURE && rise && period_cnt != '0 && busy && !done;
  end
  always_ff @(posedge clock_50_000_000 or negedge reset_l)
    if (!reset_l) {pre, period_cnt, high_cnt, div_period, period, duty_cycle, valid, locked, no_signal, overrun} <= '0;
    else if (clear) {pre, period_cnt, high_cnt, div_period, period, duty_cycle, valid, locked, no_signal, overrun} <= '0;
    else begin
      pre <= pre_n;
      period_cnt <= period_n;
      high_cnt <= high_n;
      valid <= done;
      overrun <= drop;
      if (accept) div_period <= period_cnt;
      if (done) {period, duty_cycle} <= {div_period, quotient};
      locked <= timeout ? 1'b0 : locked | done;
      no_signal <= rise ? 1'b0 : no_signal | timeout;
    end
  pulse_analyzer_serial_divide #(.DW(PERIOD_WIDTH), .QW(PERCENT_WIDTH)) divide (
    .clock_50_000_000(clock_50_000_000),
    .reset_l(reset_l),
    .abort(clear),
    .start(accept),
    .dividend({high_cnt, {PERCENT_WIDTH{1'b0}}}),
    .divisor(period_cnt),
    .busy(busy),
    .done(done),
    .quotient(quotient)
  );
endmodule

// File: tb/tb_pulse_analyzer.sv
// tb_pulse_analyzer: randomized waveforms against a waveform-level model, results checked through a scoreboard.
module tb_pulse_analyzer;
  localparam int PW = 8;
  localparam int LAT = 3 + PW + 1;
  logic clk = 0, reset_l = 0, clear = 0, sig = 0, sig50 = 0;
  logic [15:0] period, period50;
  logic [7:0] duty, duty50;
  logic valid, locked, no_signal, overrun, valid50, locked50, no_signal50, overrun50;
  longint cyc = 0;
  int passes = 0, checks = 0;
  typedef struct { longint due; longint per; longint duty; } exp_t;
  exp_t exp_q[$];
  longint ov_q[$];
  bit armed;
  longint last_rise, last_acc, fall_cyc;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  pulse_analyzer dut (
    .clock_50_000_000(clk), .reset_l(reset_l), .clear(clear), .signal_in(sig),
    .period(period), .duty_cycle(duty), .valid(valid), .locked(locked),
    .no_signal(no_signal), .overrun(overrun)
  );
  pulse_analyzer #(.GENERATION_TICKS(50)) dut50 (
    .clock_50_000_000(clk), .reset_l(reset_l), .clear(clear), .signal_in(sig50),
    .period(period50), .duty_cycle(duty50), .valid(valid50), .locked(locked50),
    .no_signal(no_signal50), .overrun(overrun50)
  );

  function automatic void check(string name, longint act, longint want);
    checks++;
    if (act == want) passes++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, want, cyc);
  endfunction

  function automatic void model_reset();
    armed = 0;
    last_acc = -1000000;
    last_rise = 0;
    fall_cyc = 0;
  endfunction

  // pin rises at cycle k: measure the previous period if armed and not timed out
  function automatic void model_rise(longint k);
    longint p;
    p = k - last_rise;
    if (armed && p <= 65535) begin
      if (k - last_acc >= PW) begin
        exp_q.push_back('{k + LAT, p, ((fall_cyc - last_rise) * 256) / p});
        last_acc = k;
      end else ov_q.push_back(k + 4);
    end
    armed = 1;
    last_rise = k;
  endfunction

  function automatic void model_clear(longint c);
    while (exp_q.size() > 0 && exp_q[$].due >= c) void'(exp_q.pop_back());
    while (ov_q.size() > 0 && ov_q[$] >= c) void'(ov_q.pop_back());
    armed = 0;
    last_acc = -1000000;
  endfunction

  task automatic wave(int h, int l);
    sig = 1;
    model_rise(cyc);
    repeat (h) @(negedge clk);
    sig = 0;
    fall_cyc = cyc;
    repeat (l) @(negedge clk);
  endtask

  task automatic check_zero(string tag);
    check({tag, " period"}, period, 0);
    check({tag, " duty"}, duty, 0);
    check({tag, " valid"}, valid, 0);
    check({tag, " locked"}, locked, 0);
    check({tag, " no_signal"}, no_signal, 0);
    check({tag, " overrun"}, overrun, 0);
  endtask

  always @(negedge clk) if (reset_l) begin
    exp_t e;
    longint o;
    if (valid) begin
      if (exp_q.size() == 0) check("unexpected valid", 1, 0);
      else begin
        e = exp_q.pop_front();
        check("valid cycle", cyc, e.due);
        check("period", period, e.per);
        check("duty", duty, e.duty);
        check("locked with valid", locked, 1);
      end
    end
    if (overrun) begin
      if (ov_q.size() == 0) check("unexpected overrun", 1, 0);
      else begin
        o = ov_q.pop_front();
        check("overrun cycle", cyc, o);
      end
    end
  end

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    check_zero("reset");
    reset_l = 1;
    @(negedge clk);
    repeat (3) wave(25, 75);
    sig = 1; model_rise(cyc); repeat (25) @(negedge clk);
    sig = 0; fall_cyc = cyc; repeat (15) @(negedge clk);
    check("locked before reset", locked, 1);
    reset_l = 0;
    model_reset();
    #1 check_zero("mid reset");
    @(negedge clk);
    reset_l = 1;
    @(negedge clk);
    repeat (4) wave(25, 75);
    check("period 25/75", period, 100);
    check("duty 25/75", duty, 64);
    sig = 1; model_rise(cyc); repeat (70000) @(negedge clk);
    check("stall no_signal", no_signal, 1);
    check("stall locked", locked, 0);
    check("stall period held", period, 100);
    check("stall duty held", duty, 64);
    sig = 0; fall_cyc = cyc; repeat (75) @(negedge clk);
    wave(25, 75);
    check("resume no_signal", no_signal, 0);
    check("resume locked", locked, 0);
    repeat (2) wave(25, 75);
    repeat (8) wave(2, 3);
    repeat (15) @(negedge clk);
    check("period 2/3", period, 5);
    check("duty 2/3", duty, 102);
    repeat (40) wave($urandom_range(1, 30), $urandom_range(1, 40));
    repeat (3) wave(500, 500);
    sig = 1; model_rise(cyc); repeat (6) @(negedge clk);
    clear = 1;
    model_clear(cyc + 1);
    @(negedge clk);
    clear = 0;
    check("clear locked", locked, 0);
    check("clear period", period, 0);
    repeat (19) @(negedge clk);
    sig = 0; fall_cyc = cyc; repeat (75) @(negedge clk);
    repeat (3) wave(25, 75);
    repeat (20) @(negedge clk);
    check("pending results", exp_q.size(), 0);
    check("pending overruns", ov_q.size(), 0);
    repeat (2) begin
      sig50 = 1; repeat (500) @(negedge clk);
      sig50 = 0; repeat (1500) @(negedge clk);
    end
    check("prescaled period", period50, 40);
    check("prescaled duty", duty50, 64);
    check("prescaled locked", locked50, 1);
    check("prescaled no_signal", no_signal50, 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
